// File: rtl/alu_32_mod.sv
// alu_32_mod: 32-bit ALU with seven combinational opcodes and a multi-cycle
// unsigned MOD.
//   clk     rising-edge clock
//   reset   asynchronous active-low reset (0 = reset asserted)
//   a, b    operands
//   select  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD,
//           110 SUB, 111 MOD
//   result  operation result (combinational; for MOD, the remainder once done)
//   done    registered MOD-complete flag
module alu_32_mod #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [2:0]  OP_MOD = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;   // dividend shifts out MSB first, quotient bits shift in
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic             w_slt;

  // Shifted partial remainder keeps its carry-out bit so divisors above
  // 2^(WIDTH-1) still compare correctly.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  // When w_ge holds the true difference is below r_div, so the low bits suffice.
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;
  assign w_slt   = ($signed(a) < $signed(b));

  // Unsigned modulo sequencer: restoring shift-subtract, one bit per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (select != OP_MOD) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          r_quot  <= a;
          r_div   <= b;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_done  <= 1'b0;
        end
        RUN: begin
          // Counter reaching WIDTH means all steps are done; this extra cycle
          // places the rise of done on the 33rd edge after the start.
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Result mux; MOD shows the remainder only once the sequencer is in DONE.
  always_comb begin
    result = '0;
    case (select)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010: result = a ^ b;
      3'b011: result = ~(a | b);
      3'b100: result = {{(WIDTH-1){1'b0}}, w_slt};
      3'b101: result = a + b;
      3'b110: result = a - b;
      3'b111: result = (r_state == DONE) ? r_rem : '0;
    endcase
  end

  assign done = r_done;

endmodule

// File: tb/tb_alu_32_mod.sv
// tb_alu_32_mod: scoreboard bench for alu_32_mod. Stimulus pushes the
// expected (result, done) for a given cycle; a negedge monitor pops and checks.
module tb_alu_32_mod;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  select;
  logic [31:0] result;
  logic        done;

  alu_32_mod #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .select (select),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned when;
    logic [31:0] res;
    logic        dn;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp;
  int    n_bad;

  // Reference model straight from the opcode table.
  function automatic logic [31:0] model(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
    case (s)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x ^ y;
      3'b011: return ~(x | y);
      3'b100: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b101: return x + y;
      3'b110: return x - y;
      default: return (y == 32'd0) ? x : (x % y);
    endcase
  endfunction

  task automatic expect_now(input string nm, input logic [31:0] r, input logic d);
    exp_t e;
    e.when = cyc;
    e.res  = r;
    e.dn   = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare on the falling edge of the cycle each item names.
  exp_t  cur;
  string cur_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: sample for cycle %0d missed (now %0d)", cur_nm, cur.when, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      n_cmp++;
      if (result !== cur.res || done !== cur.dn) begin
        n_bad++;
        $display("FAIL %s: cycle %0d result=%h done=%b, expected result=%h done=%b",
                 cur_nm, cyc, result, done, cur.res, cur.dn);
      end
    end
  end

  task automatic comb_op(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y, input string nm);
    @(posedge clk); #1;
    select = s; a = x; b = y;
    expect_now(nm, model(s, x, y), 1'b0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b0; select = 3'b000;
    expect_now("rst_pulse", a & b, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_now("rst_release", a & b, 1'b0);
  endtask

  // Start a MOD; done must rise exactly 33 edges after the starting edge.
  task automatic mod_run(input logic [31:0] x, input logic [31:0] y, input string nm,
                         input int hold, input bit scramble);
    logic [31:0] m;
    m = model(3'b111, x, y);
    @(posedge clk); #1;
    select = 3'b111; a = x; b = y;
    expect_now({nm, "_idle"}, 32'd0, 1'b0);
    for (int j = 1; j <= 33 + hold; j++) begin
      @(posedge clk); #1;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      if (j >= 34) expect_now(nm, m, 1'b1);
      else         expect_now({nm, "_busy"}, 32'd0, 1'b0);
    end
  endtask

  task automatic mod_abort(input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    select = 3'b111; a = x; b = y;
    expect_now("abort_idle", 32'd0, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      expect_now("abort_busy", 32'd0, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    expect_now("abort_rst", 32'd0, 1'b0);
    @(posedge clk); #1;
    select = 3'b101;
    expect_now("rst_comb_add", a + b, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_now("abort_release", a + b, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    select = 3'b111;
    a      = 32'd5;
    b      = 32'd3;

    // Reset behaviour: MOD reads 0, combinational ops unaffected.
    @(posedge clk); #1;
    expect_now("rst_mod_zero", 32'd0, 1'b0);
    @(posedge clk); #1;
    select = 3'b101;
    expect_now("rst_add", 32'd8, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    comb_op(3'b000, 32'h00FF550F, 32'hFF00ABFC, "and");
    comb_op(3'b001, 32'hFF00FF00, 32'h00FF5555, "or");
    comb_op(3'b010, 32'hFF00FF00, 32'h00FF5555, "xor");
    comb_op(3'b011, 32'hFF00FF00, 32'h00FF5555, "nor");
    comb_op(3'b100, 32'd82, 32'd19, "slt_gt");
    comb_op(3'b100, 32'd19, 32'd82, "slt_lt");
    comb_op(3'b100, 32'hFFFFFFFF, 32'd1, "slt_signed");
    comb_op(3'b100, 32'h80000000, 32'h7FFFFFFF, "slt_minmax");
    comb_op(3'b100, 32'd7, 32'd7, "slt_eq");
    comb_op(3'b101, 32'd19, 32'd82, "add");
    comb_op(3'b101, -32'sd5, -32'sd7, "add_neg");
    comb_op(3'b101, 32'hFFFFFFFF, 32'd1, "add_wrap");
    comb_op(3'b110, 32'd82, 32'd19, "sub");
    comb_op(3'b110, 32'd82, -32'sd19, "sub_neg");
    comb_op(3'b110, 32'd0, 32'd1, "sub_wrap");

    mod_run(32'd113, 32'd47, "mod_113_47", 3, 1'b0);
    reset_pulse();
    mod_run(32'd25, 32'd47, "mod_25_47", 3, 1'b1);
    reset_pulse();
    mod_run(32'd29, 32'd8, "mod_29_8", 3, 1'b0);
    reset_pulse();
    mod_run(32'd1234, 32'd0, "mod_div0", 2, 1'b0);
    reset_pulse();
    mod_run(32'hFFFFFFFF, 32'h80000001, "mod_bigdiv", 2, 1'b0);
    reset_pulse();

    mod_abort(32'd1000, 32'd3);
    mod_run(32'd1000, 32'd3, "mod_after_abort", 2, 1'b0);

    // Opcode switch from DONE: result follows ADD at once, done drops next edge.
    @(posedge clk); #1;
    select = 3'b101;
    expect_now("sw_add_now", a + b, 1'b1);
    @(posedge clk); #1;
    expect_now("sw_add_next", a + b, 1'b0);
    mod_run(32'd500, 32'd9, "mod_restart", 2, 1'b1);
    reset_pulse();

    for (int i = 0; i < 40; i++) begin
      comb_op(3'($urandom_range(0, 6)), $urandom, $urandom, "rand_comb");
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
      mod_run(x, y, "rand_mod", 2, 1'b1);
      reset_pulse();
    end

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected samples never checked, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_32_mod.md
Name: alu_32_mod

Overview:
- 32-bit ALU selected by a 3-bit opcode.
- AND, OR, XOR, NOR, signed set-less-than, ADD and SUB are purely combinational.
- Unsigned MOD is a multi-cycle sequential operation that signals completion on `done`.
- Used as the datapath ALU. The surrounding control waits on `done` only for MOD.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- select  input  3  opcode
- result  output  WIDTH  operation result
- done  output  1  MOD complete flag

Behaviour:
- Opcodes:
  - 000 = a AND b
  - 001 = a OR b
  - 010 = a XOR b
  - 011 = NOT(a OR b)
  - 100 = SLT: result = 1 if signed(a) < signed(b), else 0; upper 31 bits are zero
  - 101 = a + b, modulo 2^32, carry/overflow discarded
  - 110 = a - b, modulo 2^32
  - 111 = a mod b, unsigned
- Opcodes 000-110:
  - `result` follows the inputs combinationally, zero latency.
  - `done` is 0.
  - The MOD sequencer is held in IDLE.
- Reset (reset=0, asynchronous):
  - state=IDLE, remainder register=0, quotient/shift register=0, bit counter=0, done=0.
  - `result` for opcode 111 reads 0 while in reset.
  - Combinational opcodes are unaffected by reset.
- MOD sequencer, states IDLE, RUN, DONE:
  - IDLE -> RUN: on a rising edge with reset=1 and select=111.
    - Latch a (dividend) and b (divisor) internally.
    - Clear the remainder; counter=0.
  - RUN: one restoring shift-subtract step per clock, MSB first.
    - rem = {rem[30:0], dividend bit}
    - If rem >= divisor, subtract divisor.
    - Counter increments each step. After the 32nd step -> DONE.
  - Latency: `done` rises on the 33rd rising edge after the starting edge, independent of operand values.
  - DONE:
    - done=1, result=remainder.
    - Both hold while select=111 and reset=1.
  - Leaving select=111 in any state returns to IDLE on the next edge and clears done. A new MOD starts when select returns to 111.
  - Changes to a/b during RUN or DONE are ignored, because operands are latched. A new computation requires reset or leaving opcode 111.
  - Reset mid-RUN aborts immediately to IDLE with done=0.
  - While in IDLE/RUN with select=111, result=0.
  - Divide by zero (b=0): result = a, same latency, done asserted normally.
  - a < b: result = a.
- No registered outputs other than `done` and the MOD remainder.

Test Plan:
- Logic ops:
  - a=00FF550F, b=FF00ABFC, sel=000 -> result=0000010C, done=0.
  - a=FF00FF00, b=00FF5555: sel=001 -> FFFFFF55; sel=010 -> FFFFAA55; sel=011 -> 000000AA.
- SLT:
  - a=82, b=19 -> 0.
  - a=19, b=82 -> 1.
  - a=FFFFFFFF (-1), b=1 -> 1 (signed compare).
- ADD/SUB:
  - 19+82 -> 101.
  - -5 + -7 -> FFFFFFF4.
  - 82-19 -> 63.
  - 82 - (-19) -> 101.
  - 0 - 1 -> FFFFFFFF.
- MOD with the reset pulse between runs:
  - 113 mod 47 -> 19.
  - 25 mod 47 -> 25.
  - 29 mod 8 -> 5.
  - Each: done rises exactly 33 edges after start and stays high; result is stable while done=1.
- MOD edge and abort cases:
  - b=0, a=1234 -> result 1234, done after 33 edges.
  - Reset asserted 10 cycles into RUN -> done=0 immediately; a new MOD started afterwards completes correctly.
- Opcode change:
  - Switch select from 111 to 101 while in DONE -> result immediately shows a+b; done=0 after the next edge.
  - Returning to 111 restarts the full 33-cycle computation.
